mem_bus_responder: RTL

- Memory-side end of the CPU byte bus (`mem_a`/`mem_dout`/`mem_wr` in, `mem_din` out).
- Provides byte RAM and the memory-mapped I/O the CPU expects:
  - UART RX byte source and UART TX byte sink at 0x30000.
  - Cycle counter and program-stop at 0x30004.
  - The `io_buffer_full` flag.
- Sits between the cpu top and the UART/host wrapper in the FPGA/sim top; replaces the behavioural RAM + io glue.

---
 rtl/mem_bus_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_bus_responder.sv
// Memory-side end of the CPU byte bus: byte RAM plus memory-mapped UART RX/TX,
// cycle counter with coherent snapshot, and program-stop register.
module mem_bus_responder #(
  parameter int ADDR_W       = 17,
  parameter int TX_DEPTH_LOG = 3,
  parameter int FULL_MARGIN  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int              DEPTH    = 1 << TX_DEPTH_LOG;
  localparam int              CW       = TX_DEPTH_LOG + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   MARGIN_C = CW'(FULL_MARGIN);
  localparam logic [63:0]     RAM_SIZE = 64'd1 << ADDR_W;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic              is_io;
    logic              ram_ok;
    logic [2:0]        off;
    logic [ADDR_W-1:0] idx;
  } bus_req_t;

  bus_req_t req;
  logic     unused_hi;

  assign req.rd     = rdy_in & ~cpu_wr;
  assign req.wr     = rdy_in & cpu_wr;
  assign req.is_io  = (cpu_a[17:16] == 2'b11);
  assign req.ram_ok = ~req.is_io & ({46'd0, cpu_a[17:0]} < RAM_SIZE);
  assign req.off    = cpu_a[2:0];
  assign req.idx    = cpu_a[ADDR_W-1:0];
  assign unused_hi  = ^cpu_a[31:18];

  // ---------------- RAM (contents survive reset) ----------------
  logic [7:0] ram [1 << ADDR_W];

  always_ff @(posedge clk_in) begin
    if (req.wr && req.ram_ok) ram[req.idx] <= cpu_dout;
  end

  // ---------------- read mux / counter / stop ----------------
  logic [31:0] counter, snapshot;
  logic [7:0]  rd_data;
  logic        snap_ld, stop_wr, tx_wr;

  always_comb begin
    rd_data = 8'h00;
    if (req.ram_ok) begin
      rd_data = ram[req.idx];
    end else if (req.is_io) begin
      case (req.off)
        3'd0:    rd_data = rx_valid ? rx_data : 8'h00;
        3'd4:    rd_data = counter[7:0];
        3'd5:    rd_data = snapshot[15:8];
        3'd6:    rd_data = snapshot[23:16];
        3'd7:    rd_data = snapshot[31:24];
        default: rd_data = 8'h00;
      endcase
    end
  end

  assign rx_pop  = req.rd & req.is_io & (req.off == 3'd0) & rx_valid;
  assign snap_ld = req.rd & req.is_io & (req.off == 3'd4);
  assign stop_wr = req.wr & req.is_io & (req.off == 3'd4);
  assign tx_wr   = req.wr & req.is_io & (req.off == 3'd0) & (cpu_dout != 8'h00);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cpu_din      <= 8'h00;
      counter      <= '0;
      snapshot     <= '0;
      program_done <= 1'b0;
    end else begin
      counter <= counter + 32'd1;
      if (req.rd)  cpu_din      <= rd_data;
      if (snap_ld) snapshot     <= counter;
      if (stop_wr) program_done <= 1'b1;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]              fifo_mem [DEPTH];
  logic [TX_DEPTH_LOG-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]           count, next_count;
  logic                    push, push_ok, pop;
  logic [7:0]              push_data;

  assign push       = tx_wr | stop_wr;
  assign push_data  = stop_wr ? 8'h00 : cpu_dout;
  assign tx_valid   = (count != '0);
  assign tx_data    = fifo_mem[rd_ptr];
  assign pop        = tx_valid & tx_ready;
  // A pop in the same edge frees the slot, so push at full still succeeds.
  assign push_ok    = push & ((count != DEPTH_C) | pop);
  assign next_count = count + CW'(push_ok) - CW'(pop);

  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      tx_overflow    <= 1'b0;
      io_buffer_full <= 1'b0;
    end else begin
      if (push_ok)         wr_ptr      <= wr_ptr + 1'b1;
      if (pop)             rd_ptr      <= rd_ptr + 1'b1;
      if (push & ~push_ok) tx_overflow <= 1'b1;
      count          <= next_count;
      io_buffer_full <= ((DEPTH_C - next_count) <= MARGIN_C);
    end
  end

endmodule
